alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage arithmetic block of the 5-stage MIPS pipeline. It combines three functions:
- the ALU control decoder, which maps opcode and funct to a 3-bit operation;
- the 32-bit ALU datapath;
- the branch-operand forwarding selector for a BEQ sitting in the ID stage.

ALU result and control are combinational, for capture into EX/MEM. Zero and overflow status are also registered for downstream use.

## Interface
Parameters:
- `LW_OP`, 6'b100011, load opcode
- `SW_OP`, 6'b101011, store opcode
- `BEQ_OP`, 6'b000100, branch-equal opcode
- `ADDI_OP`, 6'b001000, add-immediate opcode

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  pipeline clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `ex_op`  in  6  ID/EX opcode (IR[31:26])
- `ex_funct`  in  6  ID/EX funct (IR[5:0])
- `a`  in  32  forwarded operand A
- `b`  in  32  forwarded operand B
- `alu_ctrl`  out  3  decoded ALU operation
- `alu_out`  out  32  combinational result
- `zero`  out  1  combinational; 1 when `alu_out` == 0
- `zero_q`  out  1  `zero` registered
- `ovf_q`  out  1  signed overflow of add/sub, registered
- `id_op`  in  6  IF/ID opcode
- `id_rs`  in  5  IF/ID rs
- `id_rt`  in  5  IF/ID rt
- `exmem_rd`  in  5  destination register of the instruction in EX/MEM
- `memwb_rd`  in  5  destination register of the instruction in MEM/WB
- `bfa`  out  2  branch operand A source select
- `bfb`  out  2  branch operand B source select

## Operation
ALU control decode (`alu_ctrl`):
- `ex_op` = 0 (R-type), by funct:
  - 32/33 (add/addu) → 010
  - 34/35 (sub/subu) → 110
  - 36 (and) → 000
  - 37 (or) → 001
  - 42 (slt) → 111
  - any other funct, including 0 and 8 (jr) → 010
- `LW_OP`, `SW_OP`, `ADDI_OP` → 010.
- `BEQ_OP` → 110.
- Any other opcode → 010.

ALU datapath, by `alu_ctrl`:
- 000: a & b
- 001: a | b
- 010: a + b, modulo 2^32
- 110: a − b, modulo 2^32
- 111: 32'd1 if $signed(a) < $signed(b), else 0
- 011, 101: 0
- 100: see Configuration

Overflow:
- Add: overflow = operands share a sign bit and the result's sign differs.
- Sub: overflow = operand sign bits differ and the result's sign differs from `a`.
- All other operations: overflow = 0.

Branch forward selection (per operand, `bfa` for `id_rs`, `bfb` for `id_rt`):
- If `id_op` ≠ `BEQ_OP`, the select is 00.
- If the register number is 0, the select is 00.
- Else, if the register matches `exmem_rd`, the select is 01 (EX/MEM value). This case has priority.
- Else, if the register matches `memwb_rd`, the select is 10 (MEM/WB value).
- Otherwise the select is 00 (register file).
- Code 11 is never produced.

## Timing
- `alu_ctrl`, `alu_out`, `zero`, `bfa`, `bfb` are purely combinational, with zero latency. They are valid within the same cycle as their inputs.
- `zero_q` and `ovf_q` load `zero` and the overflow flag on every rising edge of `clock`, one cycle of latency.
- Reset: if `reset` = 1 at a rising edge, `zero_q` ← 0 and `ovf_q` ← 0. Reset takes priority over the update.
- Combinational outputs do not depend on `reset`.
- There is no stall or enable input. The registered flags update every cycle.
- When EX/MEM and MEM/WB both target the same register, 01 wins.
- Wrap-around: add/sub wrap silently. 0x7FFFFFFF + 1 = 0x80000000, with `ovf_q` = 1 on the next cycle.

## Configuration
- `ALU_NOR_EN`
  - Defined: funct 39 (nor) → `alu_ctrl` 100, and `alu_ctrl` 100 computes ~(a | b).
  - Undefined: funct 39 decodes as 010 (add), and `alu_ctrl` 100 yields 0.

## Test plan
- R-type add, `ex_funct`=32, a=0x7FFFFFFF, b=1 → `alu_ctrl`=010, `alu_out`=0x80000000, `zero`=0; after the next edge `ovf_q`=1.
- `ex_op`=`BEQ_OP`, a=b=0x1234 → `alu_ctrl`=110, `alu_out`=0, `zero`=1; after the edge `zero_q`=1. Then assert `reset` → `zero_q`=0 and `ovf_q`=0 after the next edge.
- slt with a=0xFFFFFFFF, b=1 → 1. Swapped operands → 0.
- `LW_OP`, a=0x100, b=0x20 → `alu_ctrl`=010, `alu_out`=0x120. Funct 36, a=0xF0F0, b=0xFF00 → 0xF000. Funct 37 → 0xFFF0.
- `id_op`=`BEQ_OP`, `id_rs`=5, `id_rt`=6, `exmem_rd`=5, `memwb_rd`=6 → `bfa`=01, `bfb`=10.
  - With `exmem_rd`=`memwb_rd`=5 → `bfa`=01.
  - With `id_rs`=0 → `bfa`=00.
  - With `id_op`=0 → both 00.
- Funct 39, a=0, b=0:
  - `ALU_NOR_EN` defined → `alu_ctrl`=100, `alu_out`=0xFFFFFFFF.
  - `ALU_NOR_EN` undefined → `alu_ctrl`=010, `alu_out`=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU for the 5-stage MIPS pipeline.
// Contains the ALU control decoder, the 32-bit ALU datapath with registered
// zero/overflow flags, and the BEQ branch-operand forwarding selector.
// Optional feature macro: ALU_NOR_EN (adds nor, funct 39 -> alu_ctrl 100).
module alu_exec_unit #(
  parameter logic [5:0] LW_OP   = 6'b100011,
  parameter logic [5:0] SW_OP   = 6'b101011,
  parameter logic [5:0] BEQ_OP  = 6'b000100,
  parameter logic [5:0] ADDI_OP = 6'b001000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ex_op,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        zero_q,
  output logic        ovf_q,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  output logic [1:0]  bfa,
  output logic [1:0]  bfb
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  alu_op_e     op;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf;
  fwd_sel_e    sel_a;
  fwd_sel_e    sel_b;

  assign alu_ctrl = op;
  assign sum      = a + b;
  assign diff     = a - b;
  assign zero     = (alu_out == '0);
  assign bfa      = sel_a;
  assign bfb      = sel_b;

  // ALU control decode from opcode and funct; unknown encodings default to add.
  always_comb begin
    op = ALU_ADD;
    if (ex_op == 6'd0) begin
      case (ex_funct)
        6'd32, 6'd33: op = ALU_ADD;
        6'd34, 6'd35: op = ALU_SUB;
        6'd36:        op = ALU_AND;
        6'd37:        op = ALU_OR;
        6'd42:        op = ALU_SLT;
`ifdef ALU_NOR_EN
        6'd39:        op = ALU_NOR;
`endif
        default:      op = ALU_ADD;
      endcase
    end else if (ex_op == BEQ_OP) begin
      op = ALU_SUB;
    end else if ((ex_op == LW_OP) || (ex_op == SW_OP) || (ex_op == ADDI_OP)) begin
      op = ALU_ADD;
    end
  end

  // ALU datapath and signed-overflow detection for add/sub.
  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (op)
      ALU_AND: alu_out = a & b;
      ALU_OR:  alu_out = a | b;
      ALU_ADD: begin
        alu_out = sum;
        ovf     = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        alu_out = diff;
        ovf     = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT: alu_out = {31'd0, ($signed(a) < $signed(b))};
`ifdef ALU_NOR_EN
      ALU_NOR: alu_out = ~(a | b);
`endif
      default: alu_out = '0;
    endcase
  end

  // Registered status flags, updated every cycle; reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero;
      ovf_q  <= ovf;
    end
  end

  // BEQ operand forwarding: EX/MEM beats MEM/WB, register 0 never forwards.
  always_comb begin
    sel_a = FWD_REGFILE;
    sel_b = FWD_REGFILE;
    if (id_op == BEQ_OP) begin
      if (id_rs != 5'd0) begin
        if (id_rs == exmem_rd)      sel_a = FWD_EXMEM;
        else if (id_rs == memwb_rd) sel_a = FWD_MEMWB;
      end
      if (id_rt != 5'd0) begin
        if (id_rt == exmem_rd)      sel_b = FWD_EXMEM;
        else if (id_rt == memwb_rd) sel_b = FWD_MEMWB;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized self-checking bench for alu_exec_unit with a
// behavioural reference model, plus literal directed expectations.
module tb_alu_exec_unit;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  ex_op, ex_funct, id_op;
  logic [31:0] a, b;
  logic [4:0]  id_rs, id_rt, exmem_rd, memwb_rd;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero, zero_q, ovf_q;
  logic [1:0]  bfa, bfb;

  int checks = 0;
  int errors = 0;
  bit run = 0;
  logic m_zq, m_oq;

  alu_exec_unit #(.LW_OP(LW), .SW_OP(SW), .BEQ_OP(BEQ), .ADDI_OP(ADDI)) dut (
    .clock(clock), .reset(reset), .ex_op(ex_op), .ex_funct(ex_funct),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .zero(zero),
    .zero_q(zero_q), .ovf_q(ovf_q), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .bfa(bfa), .bfb(bfb)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [2:0] m_ctrl(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 32 || fn == 33) return 3'b010;
      if (fn == 34 || fn == 35) return 3'b110;
      if (fn == 36) return 3'b000;
      if (fn == 37) return 3'b001;
      if (fn == 42) return 3'b111;
`ifdef ALU_NOR_EN
      if (fn == 39) return 3'b100;
`endif
      return 3'b010;
    end
    if (op == BEQ) return 3'b110;
    return 3'b010;
  endfunction

  function automatic logic [31:0] m_out(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (c)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return 32'(sx + sy);
      3'b110: return 32'(sx - sy);
      3'b111: return (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_NOR_EN
      3'b100: return ~(x | y);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Overflow = true signed result does not fit in 32 bits.
  function automatic logic m_ovf(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    longint r;
    if (c == 3'b010) r = longint'($signed(x)) + longint'($signed(y));
    else if (c == 3'b110) r = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [5:0] op, input logic [4:0] r,
                                       input logic [4:0] em, input logic [4:0] mw);
    if (op != BEQ || r == 0) return 2'b00;
    if (r == em) return 2'b01;
    if (r == mw) return 2'b10;
    return 2'b00;
  endfunction

  // Model of the registered flags.
  always @(posedge clock) begin
    if (reset) begin
      m_zq <= 1'b0;
      m_oq <= 1'b0;
    end else begin
      m_zq <= (m_out(m_ctrl(ex_op, ex_funct), a, b) == 32'd0);
      m_oq <= m_ovf(m_ctrl(ex_op, ex_funct), a, b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (run) begin
      logic [2:0]  c;
      logic [31:0] r;
      c = m_ctrl(ex_op, ex_funct);
      r = m_out(c, a, b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(c));
      chk("alu_out", alu_out, r);
      chk("zero", 32'(zero), 32'(r == 32'd0));
      chk("zero_q", 32'(zero_q), 32'(m_zq));
      chk("ovf_q", 32'(ovf_q), 32'(m_oq));
      chk("bfa", 32'(bfa), 32'(m_fwd(id_op, id_rs, exmem_rd, memwb_rd)));
      chk("bfb", 32'(bfb), 32'(m_fwd(id_op, id_rt, exmem_rd, memwb_rd)));
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'(b);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [10];
    ops = '{6'd0, LW, SW, BEQ, ADDI, 6'd0};
    fns = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd8};
    reset = 1; ex_op = 0; ex_funct = 32; a = 0; b = 0;
    id_op = 0; id_rs = 0; id_rt = 0; exmem_rd = 0; memwb_rd = 0;
    next_cycle();
    next_cycle();
    chk("reset zero_q", 32'(zero_q), 32'd0);
    chk("reset ovf_q", 32'(ovf_q), 32'd0);
    reset = 0;
    run = 1;

    // Directed literal expectations.
    ex_op = 0; ex_funct = 32; a = 32'h7FFFFFFF; b = 1; #2;
    chk("add ctrl", 32'(alu_ctrl), 32'b010);
    chk("add wrap", alu_out, 32'h80000000);
    chk("add zero", 32'(zero), 32'd0);
    next_cycle();
    chk("add ovf_q", 32'(ovf_q), 32'd1);

    ex_op = BEQ; a = 32'h1234; b = 32'h1234; #2;
    chk("beq ctrl", 32'(alu_ctrl), 32'b110);
    chk("beq out", alu_out, 32'd0);
    chk("beq zero", 32'(zero), 32'd1);
    next_cycle();
    chk("beq zero_q", 32'(zero_q), 32'd1);
    chk("beq ovf_q", 32'(ovf_q), 32'd0);
    reset = 1;
    next_cycle();
    chk("rst zero_q", 32'(zero_q), 32'd0);
    chk("rst ovf_q", 32'(ovf_q), 32'd0);
    reset = 0;

    ex_op = 0; ex_funct = 42; a = 32'hFFFFFFFF; b = 1; #2;
    chk("slt neg", alu_out, 32'd1);
    a = 1; b = 32'hFFFFFFFF; #2;
    chk("slt swap", alu_out, 32'd0);
    ex_op = LW; a = 32'h100; b = 32'h20; #2;
    chk("lw ctrl", 32'(alu_ctrl), 32'b010);
    chk("lw out", alu_out, 32'h120);
    ex_op = 0; ex_funct = 36; a = 32'hF0F0; b = 32'hFF00; #2;
    chk("and", alu_out, 32'hF000);
    ex_funct = 37; #2;
    chk("or", alu_out, 32'hFFF0);
    ex_funct = 39; a = 0; b = 0; #2;
`ifdef ALU_NOR_EN
    chk("nor ctrl", 32'(alu_ctrl), 32'b100);
    chk("nor out", alu_out, 32'hFFFFFFFF);
`else
    chk("f39 ctrl", 32'(alu_ctrl), 32'b010);
    chk("f39 out", alu_out, 32'd0);
`endif
    id_op = BEQ; id_rs = 5; id_rt = 6; exmem_rd = 5; memwb_rd = 6; #2;
    chk("fwd bfa ex", 32'(bfa), 32'b01);
    chk("fwd bfb mw", 32'(bfb), 32'b10);
    memwb_rd = 5; #2;
    chk("fwd prio", 32'(bfa), 32'b01);
    id_rs = 0; exmem_rd = 0; #2;
    chk("fwd r0", 32'(bfa), 32'b00);
    id_rs = 5; exmem_rd = 5; id_op = 0; #2;
    chk("fwd nonbeq a", 32'(bfa), 32'b00);
    chk("fwd nonbeq b", 32'(bfb), 32'b00);
    next_cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      ex_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      ex_funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
      b = rand_operand();
      a = rand_operand();
      id_op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : BEQ;
      id_rs = 5'($urandom_range(0, 4));
      id_rt = 5'($urandom_range(0, 4));
      exmem_rd = 5'($urandom_range(0, 4));
      memwb_rd = 5'($urandom_range(0, 4));
      next_cycle();
    end

    @(negedge clock);
    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
